bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the multi-cycle successor to the combinational 8-bit converter. It takes any unsigned input width and any output digit count, adds valid/ready handshakes on both sides, and reports the number of significant digits. It sits between arithmetic/datapath results and the display/formatting logic, where conversion latency is acceptable and area matters.

## Interface
- WIDTH, 8, binary input width in bits (≥1).
- DIGITS, 3, BCD output digits. The implementation must reject (elaboration-time error) DIGITS < ceil(WIDTH·log10 2); for WIDTH=16 the minimum is 5.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  block can accept a new value.
- in_bin  input  WIDTH  unsigned binary operand.
- out_valid  output  1  out_bcd/out_ndigits are valid.
- out_ready  input  1  consumer accepts result.
- out_bcd  output  4·DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- out_ndigits  output  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS; 0 when out_valid=0.

## Operation
- FSM states: IDLE, CONV, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready at an edge:
  - load the binary shift register with in_bin;
  - clear the BCD accumulator to 0;
  - load the bit counter with WIDTH;
  - go to CONV.
- CONV: in_ready=0, out_valid=0. Each cycle:
  - every 4-bit accumulator digit ≥5 gets +3, with no carry between digits;
  - then {accumulator, shift register} shifts left by 1, so the binary MSB enters digit 0 bit 0;
  - the counter decrements.
  - When the counter reaches 0 (after WIDTH shifts), latch the accumulator into out_bcd and go to HOLD.
- HOLD: out_valid=1 and out_bcd is stable.
  - out_ndigits = 1 + index of the highest nonzero digit; it is 1 if out_bcd=0.
  - On out_valid&out_ready, go to IDLE.
- in_valid is ignored outside IDLE. in_bin is sampled only on the accept edge and may change afterwards.
- Values for the add-3 step are always 0..9 before adjust, so the accumulator never overflows given a legal DIGITS.
- Reset (any state, including mid-CONV or HOLD):
  - next state IDLE;
  - out_valid=0, out_bcd=0, out_ndigits=0;
  - shift register, accumulator and counter cleared.
  - An aborted conversion produces no result.
- During the reset cycle in_ready=0. From the first cycle after rst deasserts, in_ready=1.

## Timing
- Accept at edge E0 → CONV for WIDTH cycles → out_valid rises after edge E_WIDTH. Latency is WIDTH cycles from accept to result.
- out_valid stays high and out_bcd/out_ndigits are constant until the handshake edge. There is no combinational path from out_ready to out_valid or out_bcd.
- Handshake edge (HOLD→IDLE): out_valid=0 and in_ready=1 in the next cycle. A new accept can occur at the following edge.
- Minimum period per conversion is WIDTH+2 cycles (accept, WIDTH shifts, output handshake). There is no overlap of input and output phases.
- in_ready depends only on state; it is registered or state-decoded, never from in_valid.
- out_ndigits may be combinational from the out_bcd register, gated by out_valid.

## Test plan
- WIDTH=8, DIGITS=3:
  - After reset, in_bin=255 with out_ready=1 → out_valid exactly 8 cycles after accept, out_bcd=0x255, out_ndigits=3.
  - Then in_bin=0 → out_bcd=0x000, out_ndigits=1.
- Sweep in_bin 0..255 back-to-back with random out_ready → each result equals the decimal digits of in_bin.
  - out_ndigits is 1 for 0–9, 2 for 10–99, 3 for 100–255, with no lost or duplicated result.
- Backpressure: accept 100, hold out_ready=0 for 20 cycles.
  - out_valid must stay 1 with out_bcd=0x100 and out_ndigits=3 throughout.
  - in_ready must stay 0 throughout.
  - in_valid pulses with other values during this window must be ignored.
- Reset mid-conversion: accept 156, assert rst on cycle 4 of CONV.
  - Next cycle: out_valid=0, out_bcd=0, in_ready=1 after release.
  - A following 45 → 0x045, with no 0x156 ever presented.
- WIDTH=16, DIGITS=5: 65535 → 0x65535 after 16 cycles, out_ndigits=5; 1000 → 0x01000, out_ndigits=4.
- Reset alone (no accept) → out_valid=0, out_ndigits=0, out_bcd=0 after release.
  - in_ready=0 during the reset cycle and 1 from the first cycle after release.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on both sides and a significant-digit count.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_bin,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [4*DIGITS-1:0]            out_bcd,
   output logic [$clog2(DIGITS+1)-1:0]    out_ndigits
);

   // Digits needed for 2^WIDTH-1, i.e. ceil(WIDTH*log10(2)) in fixed point
   localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
   localparam int CW         = $clog2(WIDTH + 1);
   localparam int NW         = $clog2(DIGITS + 1);

   if (WIDTH < 1) begin : g_width_check
      $error("bin2bcd_seq: WIDTH must be at least 1");
   end

   if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS too small to hold the largest WIDTH-bit value");
   end

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      HOLD
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [WIDTH-1:0]      shreg;
   logic [4*DIGITS-1:0]   acc;
   logic [4*DIGITS-1:0]   acc_adj;
   logic [4*DIGITS-1:0]   acc_next;
   logic [CW-1:0]         cnt;
   logic [NW-1:0]         nd;

   // State register; reset always returns to IDLE, abandoning any conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode: accept in IDLE, shift WIDTH times, hold until consumed
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid) next_state = CONV;
         CONV: if (cnt == CW'(1)) next_state = HOLD;
         HOLD: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake flags are pure state decodes; in_ready is also held low while reset is asserted
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == HOLD);
   end

   // Add-3 correction on every digit of 5 or more, then shift in the next binary MSB
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
      acc_next = {acc_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
   end

   // Datapath: load on accept, step once per CONV cycle, capture the result on the last shift
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         out_bcd <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg <= in_bin;
                  acc   <= '0;
                  cnt   <= CW'(WIDTH);
               end
            end
            CONV: begin
               shreg <= shreg << 1;
               acc   <= acc_next;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  out_bcd <= acc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Significant digits: one past the highest nonzero digit, minimum one, zero when idle
   always_comb begin
      nd = NW'(1);
      for (int i = 1; i < DIGITS; i++) begin
         if (out_bcd[4*i +: 4] != 4'd0) begin
            nd = NW'(i + 1);
         end
      end
      out_ndigits = out_valid ? nd : '0;
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit/3-digit instance and a 16-bit/5-digit instance.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [7:0]  a_in_bin = '0;
   logic        a_out_valid;
   logic        a_out_ready = 1'b0;
   logic [11:0] a_out_bcd;
   logic [1:0]  a_out_ndigits;

   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [15:0] b_in_bin = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [19:0] b_out_bcd;
   logic [2:0]  b_out_ndigits;

   int pass_count  = 0;
   int check_count = 0;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (a_in_valid),
      .in_ready    (a_in_ready),
      .in_bin      (a_in_bin),
      .out_valid   (a_out_valid),
      .out_ready   (a_out_ready),
      .out_bcd     (a_out_bcd),
      .out_ndigits (a_out_ndigits)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (b_in_valid),
      .in_ready    (b_in_ready),
      .in_bin      (b_in_bin),
      .out_valid   (b_out_valid),
      .out_ready   (b_out_ready),
      .out_bcd     (b_out_bcd),
      .out_ndigits (b_out_ndigits)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Convert one value on the 8-bit instance, holding the result for 'hold' cycles before consuming it
   task automatic applyStimulus(input int v, input int hold);
      int          cycles;
      logic [31:0] exp_bcd;
      logic [31:0] exp_nd;
      exp_bcd = 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      exp_nd  = (v < 10) ? 32'd1 : (v < 100) ? 32'd2 : 32'd3;
      a_out_ready = (hold == 0);
      a_in_bin    = 8'(v);
      a_in_valid  = 1'b1;
      checkOutput("a_ready_before_accept", 32'(a_in_ready), 32'd1);
      tick();
      a_in_valid = 1'b0;
      a_in_bin   = ~8'(v);
      cycles = 0;
      while (cycles < 40) begin
         tick();
         cycles++;
         if (a_out_valid) break;
      end
      checkOutput("a_latency", 32'(cycles), 32'd8);
      repeat (hold) tick();
      checkOutput("a_bcd", 32'(a_out_bcd), exp_bcd);
      checkOutput("a_ndigits", 32'(a_out_ndigits), exp_nd);
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      checkOutput("a_valid_after_hs", 32'(a_out_valid), 32'd0);
      checkOutput("a_ready_after_hs", 32'(a_in_ready), 32'd1);
   endtask

   // Convert one value on the 16-bit instance with out_ready held high
   task automatic runWide(input int v, input logic [31:0] exp_bcd, input logic [31:0] exp_nd);
      int cycles;
      b_out_ready = 1'b1;
      b_in_bin    = 16'(v);
      b_in_valid  = 1'b1;
      tick();
      b_in_valid = 1'b0;
      cycles = 0;
      while (cycles < 60) begin
         tick();
         cycles++;
         if (b_out_valid) break;
      end
      checkOutput("b_latency", 32'(cycles), 32'd16);
      checkOutput("b_bcd", 32'(b_out_bcd), exp_bcd);
      checkOutput("b_ndigits", 32'(b_out_ndigits), exp_nd);
      tick();
      b_out_ready = 1'b0;
      checkOutput("b_valid_after_hs", 32'(b_out_valid), 32'd0);
   endtask

   // Directed sequence
   initial begin
      int   cycles;
      logic saw_valid;

      // Reset alone
      tick();
      checkOutput("ready_during_reset", 32'(a_in_ready), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("valid_after_reset", 32'(a_out_valid), 32'd0);
      checkOutput("ndigits_after_reset", 32'(a_out_ndigits), 32'd0);
      checkOutput("bcd_after_reset", 32'(a_out_bcd), 32'd0);
      checkOutput("ready_after_reset", 32'(a_in_ready), 32'd1);
      checkOutput("b_bcd_after_reset", 32'(b_out_bcd), 32'd0);

      // Full-scale and zero
      applyStimulus(255, 0);
      applyStimulus(0, 0);

      // Backpressure with ignored input pulses
      a_in_bin   = 8'd100;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      cycles = 0;
      while (cycles < 40 && !a_out_valid) begin
         tick();
         cycles++;
      end
      checkOutput("bp_latency", 32'(cycles), 32'd8);
      for (int k = 0; k < 20; k++) begin
         a_in_valid = k[0];
         a_in_bin   = 8'd77;
         tick();
         checkOutput("bp_valid", 32'(a_out_valid), 32'd1);
         checkOutput("bp_bcd", 32'(a_out_bcd), 32'h100);
         checkOutput("bp_ndigits", 32'(a_out_ndigits), 32'd3);
         checkOutput("bp_ready", 32'(a_in_ready), 32'd0);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      checkOutput("bp_valid_after_hs", 32'(a_out_valid), 32'd0);
      applyStimulus(9, 2);

      // Reset on the fourth CONV cycle
      a_in_bin   = 8'd156;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      checkOutput("midconv_ready_in_reset", 32'(a_in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midconv_valid", 32'(a_out_valid), 32'd0);
      checkOutput("midconv_bcd", 32'(a_out_bcd), 32'd0);
      checkOutput("midconv_ndigits", 32'(a_out_ndigits), 32'd0);
      checkOutput("midconv_ready", 32'(a_in_ready), 32'd1);
      saw_valid = 1'b0;
      repeat (12) begin
         tick();
         saw_valid = saw_valid | a_out_valid;
      end
      checkOutput("midconv_no_stale_result", 32'(saw_valid), 32'd0);
      applyStimulus(45, 1);

      // Sweep every 8-bit value with random consumer stalls
      for (int v = 0; v < 256; v++) begin
         applyStimulus(v, int'($urandom_range(0, 3)));
      end

      // Wide instance
      runWide(65535, 32'h65535, 32'd5);
      runWide(1000, 32'h01000, 32'd4);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
